// File: rtl/log2_pkg.sv
// Shared definitions for the log2 core and its request arbiter.
package log2_pkg;

  localparam int unsigned LOG2_IN_W     = 11;  // ufix11_En10 operand
  localparam int unsigned LOG2_IN_FRAC  = 10;
  localparam int unsigned LOG2_OUT_W    = 11;  // sfix11_En10 result
  localparam int unsigned LOG2_OUT_FRAC = 10;

  // Tag channel field is sized for the largest supported requester count (8).
  localparam int unsigned TAG_CH_W = 3;

  typedef struct packed {
    logic                vld;
    logic [TAG_CH_W-1:0] ch;
  } log2_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: searches req starting just after ptr.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  input  logic                      enable,
  output logic [NUM_CH-1:0]         gnt
);

  logic found;

  // First requester at or after ptr+1 (mod NUM_CH) wins; nothing when disabled.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (enable && !found && req[k] && (k == ((32'(ptr) + off) % NUM_CH))) begin
          gnt[k] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/log2_share_arbiter.sv
// Shares one fixed-latency log2 core between NUM_CH requesters and routes results back.
module log2_share_arbiter
  import log2_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CORE_LAT = 2
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic                          i_EN,
  input  logic [NUM_CH-1:0]             i_REQ_VALID,
  input  logic [NUM_CH*LOG2_IN_W-1:0]   i_REQ_DATA,
  output logic [NUM_CH-1:0]             o_REQ_READY,
  output logic                          o_CORE_RSTn,
  output logic                          o_CORE_EN,
  output logic                          o_CORE_DATA_VALID,
  output logic [LOG2_IN_W-1:0]          o_CORE_DATA,
  input  logic                          i_CORE_VALID,
  input  logic                          i_CORE_LOG2_VALID,
  input  logic [LOG2_OUT_W-1:0]         i_CORE_LOG2,
  output logic [NUM_CH-1:0]             o_RES_VALID,
  output logic [LOG2_OUT_W-1:0]         o_RES_LOG2,
  output logic                          o_RES_DOMAIN_ERR,
  output logic                          o_BUSY,
  output logic                          o_SEQ_ERR
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]     gnt;
  logic [CH_W-1:0]       ptr_q;
  logic                  xfer;
  logic [CH_W-1:0]       gnt_ptr;
  logic [TAG_CH_W-1:0]   gnt_ch;
  logic [LOG2_IN_W-1:0]  gnt_data;

  logic                  iss_vld_q;
  logic [TAG_CH_W-1:0]   iss_ch_q;
  logic [LOG2_IN_W-1:0]  iss_data_q;

  log2_tag_t             tag_q [CORE_LAT];
  log2_tag_t             tail;

  logic [NUM_CH-1:0]     res_d;
  logic                  strobe;
  logic [NUM_CH-1:0]     res_valid_q;
  logic [LOG2_OUT_W-1:0] res_log2_q;
  logic                  dom_err_q;
  logic                  seq_err_q;
  logic                  busy;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr_arbiter (
    .req    (i_REQ_VALID),
    .ptr    (ptr_q),
    .enable (i_EN),
    .gnt    (gnt)
  );

  // Decode the one-hot grant into channel index and selected operand.
  always_comb begin
    gnt_ptr  = '0;
    gnt_ch   = '0;
    gnt_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (gnt[k]) begin
        gnt_ptr  = CH_W'(k);
        gnt_ch   = TAG_CH_W'(k);
        gnt_data = i_REQ_DATA[k*LOG2_IN_W +: LOG2_IN_W];
      end
    end
    xfer = |(gnt & i_REQ_VALID);
  end

  // Issue register and round-robin pointer; both frozen while i_EN is low.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      iss_vld_q  <= 1'b0;
      iss_ch_q   <= '0;
      iss_data_q <= '0;
      ptr_q      <= CH_W'(NUM_CH - 1);
    end else if (i_EN) begin
      iss_vld_q <= xfer;
      if (xfer) begin
        iss_ch_q   <= gnt_ch;
        iss_data_q <= gnt_data;
        ptr_q      <= gnt_ptr;
      end
    end
  end

  // Tag pipeline mirrors the core's enabled-cycle latency.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      for (int unsigned i = 0; i < CORE_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else if (i_EN) begin
      tag_q[0] <= {iss_vld_q, iss_ch_q};
      for (int unsigned i = 1; i < CORE_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Route the tail tag to a one-hot strobe and compute the busy flag.
  always_comb begin
    tail   = tag_q[CORE_LAT-1];
    strobe = i_EN && tail.vld;
    res_d  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      res_d[k] = strobe && (tail.ch == TAG_CH_W'(k));
    end
    busy = iss_vld_q;
    for (int unsigned i = 0; i < CORE_LAT; i++) begin
      busy = busy | tag_q[i].vld;
    end
  end

  // Registered result, domain flag and sticky core/enable mismatch flag.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      res_valid_q <= '0;
      res_log2_q  <= '0;
      dom_err_q   <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      res_valid_q <= res_d;
      dom_err_q   <= strobe & ~i_CORE_LOG2_VALID;
      if (strobe) begin
        res_log2_q <= i_CORE_LOG2;
      end
      seq_err_q <= seq_err_q | (i_CORE_VALID != i_EN);
    end
  end

  assign o_REQ_READY       = gnt;
  assign o_CORE_RSTn       = ~i_RST;
  assign o_CORE_EN         = i_EN;
  assign o_CORE_DATA_VALID = iss_vld_q;
  assign o_CORE_DATA       = iss_data_q;
  assign o_RES_VALID       = res_valid_q;
  assign o_RES_LOG2        = res_log2_q;
  assign o_RES_DOMAIN_ERR  = dom_err_q;
  assign o_BUSY            = busy;
  assign o_SEQ_ERR         = seq_err_q;

endmodule
